wide_add_sched: RTL and testbench

WIDE_ADD_SCHED -- requirements
Module: wide_add_sched

---
 rtl/wide_add_sched.sv | 133 +++++++++++++
 tb/tb_wide_add_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sched.sv
`timescale 1ns/1ps
// Two-requester wide adder/subtractor that time-shares one external 16-bit adder,
// walking the operands one slice per cycle and arbitrating requesters round-robin.
module wide_add_sched #(
  parameter  int unsigned BEATS = 4,
  localparam int unsigned W     = 16 * BEATS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_sub,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_id,
  output logic [15:0]  add_a,
  output logic [15:0]  add_b,
  output logic         add_cin,
  input  logic [15:0]  add_sum,
  input  logic         add_cout
);

  localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           lp_q;
  logic           cin_q;
  logic           cout_q;
  logic           id_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   sum_q;

  logic           grant_d;
  logic           hs_d;
  logic           sub_d;
  logic [W-1:0]   a_d;
  logic [W-1:0]   b_d;
  logic           last_d;

  // Contention goes to the requester that was not granted last time.
  always_comb begin
    grant_d    = (req0_valid & req1_valid) ? ~lp_q : req1_valid;
    req0_ready = ~rst & (state_q == IDLE) & req0_valid & ~grant_d;
    req1_ready = ~rst & (state_q == IDLE) & req1_valid &  grant_d;
    hs_d       = req0_ready | req1_ready;
    sub_d      = grant_d ? req1_sub : req0_sub;
    a_d        = grant_d ? req1_a : req0_a;
    b_d        = grant_d ? req1_b : req0_b;
    last_d     = (cnt_q == CW'(BEATS - 1));
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == BUSY) begin
      for (int unsigned i = 0; i < BEATS; i++) begin
        if (cnt_q == CW'(i)) begin
          add_a = a_q[16*i +: 16];
          add_b = b_q[16*i +: 16];
        end
      end
      add_cin = cin_q;
    end
  end

  always_comb begin
    rsp_valid = (state_q == DONE);
    rsp_sum   = sum_q;
    rsp_cout  = cout_q;
    rsp_id    = id_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lp_q    <= 1'b1;
      cin_q   <= 1'b0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs_d) begin
            // Subtraction is a + ~b + 1: invert b once here, seed the carry with sub.
            a_q     <= a_d;
            b_q     <= sub_d ? ~b_d : b_d;
            cin_q   <= sub_d;
            id_q    <= grant_d;
            lp_q    <= grant_d;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          for (int unsigned i = 0; i < BEATS; i++) begin
            if (cnt_q == CW'(i)) sum_q[16*i +: 16] <= add_sum;
          end
          cin_q <= add_cout;
          if (last_d) begin
            cnt_q   <= '0;
            cout_q  <= add_cout;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sched.sv
`timescale 1ns/1ps
// Scoreboard bench for wide_add_sched: behavioural arithmetic/arbitration model,
// stand-in 16-bit adder, directed corner cases and a randomized two-requester run.
module tb_wide_add_sched;

  localparam int unsigned BEATS = 4;
  localparam int unsigned W     = 16 * BEATS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_sub = 1'b0, req1_sub = 1'b0;
  logic         rsp_valid, rsp_cout, rsp_id;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_sum;
  logic [15:0]  add_a, add_b, add_sum;
  logic         add_cin, add_cout;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
    int           due;
  } exp_t;

  exp_t sbq[$];
  int   grant_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic m_idle = 1'b1;
  logic lp_m   = 1'b1;
  int   ndone;

  wide_add_sched #(.BEATS(BEATS)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  // The shared adder lives outside the block.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Reference model and response monitor.
  always @(negedge clk) begin
    logic e0, e1, ev, g, s;
    logic [W-1:0] a, b;
    exp_t x;
    if (rst) begin
      chk("rst_rsp_sum", rsp_sum, '0);
      chk("rst_ctrl", {rsp_valid, rsp_cout, rsp_id, req0_ready, req1_ready, add_cin}, '0);
      chk("rst_adder", {add_a, add_b}, '0);
      sbq.delete();
      m_idle = 1'b1;
      lp_m   = 1'b1;
    end else begin
      e0 = m_idle & req0_valid & (~req1_valid | lp_m);
      e1 = m_idle & req1_valid & (~req0_valid | ~lp_m);
      chk("readies", {req1_ready, req0_ready}, {e1, e0});
      ev = !m_idle && sbq.size() > 0 && cyc >= sbq[0].due;
      chk("rsp_valid", rsp_valid, ev);
      if (m_idle) chk("adder_idle_zero", {add_cin, add_a, add_b}, '0);
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          chk("rsp_sum", rsp_sum, sbq[0].sum);
          chk("rsp_cout_id", {rsp_cout, rsp_id}, {sbq[0].cout, sbq[0].id});
        end
      end
      if (ev && rsp_ready) begin
        void'(sbq.pop_front());
        m_idle = 1'b1;
      end else if (e0 | e1) begin
        g = e1;
        a = g ? req1_a : req0_a;
        b = g ? req1_b : req0_b;
        s = g ? req1_sub : req0_sub;
        if (s) begin
          x.sum  = a - b;
          x.cout = (a >= b);
        end else begin
          {x.cout, x.sum} = {1'b0, a} + {1'b0, b};
        end
        x.id  = g;
        x.due = cyc + BEATS + 1;
        sbq.push_back(x);
        grant_log.push_back(int'(g));
        lp_m   = g;
        m_idle = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic do_req(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, output int waited);
    bit ok = 0;
    waited = 0;
    if (id) begin req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1; end
    while (!ok && waited < 300) begin
      @(negedge clk);
      waited++;
      ok = id ? req1_ready : req0_ready;
    end
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b0; req1_a = rnd_op(); req1_b = rnd_op(); req1_sub = ~sub; end
    else    begin req0_valid = 1'b0; req0_a = rnd_op(); req0_b = rnd_op(); req0_sub = ~sub; end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no ready for req%0d expected accept", id);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(m_idle && sbq.size() == 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int w, k;
    int exp_g[4] = '{0, 1, 0, 1};
    logic [W-1:0] ra;

    do_reset();

    do_req(0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, w);
    wait_idle();
    do_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, w);
    wait_idle();
    do_req(1, 64'd5, 64'd7, 1'b1, w);
    wait_idle();
    do_req(1, 64'd7, 64'd5, 1'b1, w);
    wait_idle();

    // Fairness: both requesters keep valid high for four operations.
    do_reset();
    grant_log.delete();
    fork
      begin int t; do_req(0, rnd_op(), rnd_op(), 1'b0, t); do_req(0, rnd_op(), rnd_op(), 1'b1, t); end
      begin int t; do_req(1, rnd_op(), rnd_op(), 1'b1, t); do_req(1, rnd_op(), rnd_op(), 1'b0, t); end
    join
    wait_idle();
    chk("grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) chk("grant_order", grant_log[i], exp_g[i]);

    // Backpressure with a competing request waiting.
    rsp_ready = 1'b0;
    do_req(1, rnd_op(), rnd_op(), 1'b0, w);
    fork
      begin int t; do_req(0, rnd_op(), rnd_op(), 1'b1, t); end
    join_none
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    chk("bp_reached_done", rsp_valid, 1'b1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait fork;
    wait_idle();

    // Reset in the middle of an operation.
    ra = {$urandom, $urandom};
    do_req(0, ra, rnd_op(), 1'b0, w);
    @(posedge clk);
    @(posedge clk); #1;
    chk("slice2_before_reset", add_a, ra[47:32]);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_outputs", {rsp_valid, rsp_cout, rsp_id, req0_ready, req1_ready, add_cin, add_a, add_b}, '0);
    chk("async_reset_sum", rsp_sum, '0);
    @(posedge clk); #1 rst = 1'b0;
    do_req(1, rnd_op(), rnd_op(), 1'b1, w);
    chk("accept_first_cycle_after_reset", w, 1);
    wait_idle();

    // Randomized traffic with random consumer backpressure.
    ndone = 0;
    fork
      begin
        int gap, t;
        for (int i = 0; i < 25; i++) begin
          gap = $urandom_range(0, 3);
          repeat (gap) begin @(posedge clk); #1; end
          do_req(0, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), t);
        end
        ndone++;
      end
      begin
        int gap, t;
        for (int i = 0; i < 25; i++) begin
          gap = $urandom_range(0, 3);
          repeat (gap) begin @(posedge clk); #1; end
          do_req(1, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), t);
        end
        ndone++;
      end
      begin
        while (ndone < 2) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
        rsp_ready = 1'b1;
      end
    join
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
